// File: rtl/iter_divider_if.sv
// ----------------------------------------------------------------------------
// iter_divider_if
//   Divide request/response bundle between the EX stage and iter_divider.
//   Signal names keep their _i/_o suffixes as seen from the divider.
//
//   div_en_i      EX -> div   divide request, held until the result is taken
//   div_signed_i  EX -> div   1 = signed, 0 = unsigned
//   divisor_i     EX -> div   divisor, sampled at accept
//   dividend_i    EX -> div   dividend, sampled at accept
//   div_ack_i     EX -> div   EX consumed the result
//   quotient_o    div -> EX   quotient, valid while finished_o=1
//   remainder_o   div -> EX   remainder, valid while finished_o=1
//   finished_o    div -> EX   result valid
//   busy_o        div -> EX   operation in flight or result pending
//
//   modport master : EX stage side
//   modport slave  : divider side
// ----------------------------------------------------------------------------
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             div_en_i;
  logic             div_signed_i;
  logic [WIDTH-1:0] divisor_i;
  logic [WIDTH-1:0] dividend_i;
  logic             div_ack_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             finished_o;
  logic             busy_o;

  modport master (
    output div_en_i, div_signed_i, divisor_i, dividend_i, div_ack_i,
    input  quotient_o, remainder_o, finished_o, busy_o
  );

  modport slave (
    input  div_en_i, div_signed_i, divisor_i, dividend_i, div_ack_i,
    output quotient_o, remainder_o, finished_o, busy_o
  );
endinterface

// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// iter_divider
//   Multi-cycle radix-2 restoring integer divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
//   One quotient bit per cycle on operand magnitudes; signs are applied in a
//   final fix-up cycle. Divide by zero yields all-ones quotient and the raw
//   dividend as remainder. Quotient truncates toward zero, remainder follows
//   the sign of the dividend.
//
//   clk    clock
//   rst_n  synchronous active-low reset; the pipeline also uses it as flush
//   bus    iter_divider_if.slave (request operands, results, finished/busy)
// ----------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem;        // partial remainder
  logic [WIDTH-1:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr;       // divisor magnitude
  logic [WIDTH-1:0] raw_dvnd;   // dividend as presented, for the divide-by-zero result
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_ext;    // shifted remainder, one bit wider than the operands
  logic [WIDTH:0]   trial;

  logic             dvnd_neg;
  logic             dvsr_neg;

  assign dvnd_neg = bus.div_signed_i & bus.dividend_i[WIDTH-1];
  assign dvsr_neg = bus.div_signed_i & bus.divisor_i[WIDTH-1];

  // Restoring step: rem_ext is always below 2*dvsr, so WIDTH+1 bits never
  // overflow and trial's MSB is the borrow.
  assign rem_ext = {rem, quo[WIDTH-1]};
  assign trial   = rem_ext - {1'b0, dvsr};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational process gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.div_en_i)         state_nxt = BUSY;
      BUSY: if (cnt == CNT_W'(1))     state_nxt = FIX;
      FIX:                            state_nxt = DONE;
      // A held div_en_i without ack is a stalled EX, not a new request.
      DONE: if (bus.div_ack_i || !bus.div_en_i) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers carry no reset; each operation reloads them at
  // accept, and only control state and visible outputs need a defined value.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (bus.div_en_i) begin
          quo      <= dvnd_neg ? -bus.dividend_i : bus.dividend_i;
          dvsr     <= dvsr_neg ? -bus.divisor_i  : bus.divisor_i;
          rem      <= '0;
          raw_dvnd <= bus.dividend_i;
          neg_q    <= dvnd_neg ^ dvsr_neg;
          neg_r    <= dvnd_neg;
          div0     <= (bus.divisor_i == '0);
          cnt      <= CNT_W'(WIDTH);
        end
      end
      BUSY: begin
        rem <= trial[WIDTH] ? rem_ext[WIDTH-1:0] : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.quotient_o  <= '0;
      bus.remainder_o <= '0;
    end else if (state == FIX) begin
      if (div0) begin
        bus.quotient_o  <= '1;
        bus.remainder_o <= raw_dvnd;
      end else begin
        bus.quotient_o  <= neg_q ? -quo : quo;
        bus.remainder_o <= neg_r ? -rem : rem;
      end
    end
  end

  assign bus.finished_o = (state == DONE);
  assign bus.busy_o     = (state != IDLE);

endmodule
